// File: rtl/s4ga_pkg.sv
// Shared sizing helpers, evaluation-mode enum and index decode constants for the
// second-generation serially configured LUT fabric.
package s4ga_pkg;

  typedef enum logic {
    SEQ  = 1'b0,
    SYNC = 1'b1
  } mode_e;

  // Index decode codes; the top module slices the low N_W bits.
  localparam logic [31:0] IDX_ONE = 32'hFFFF_FFFF;
  localparam logic [31:0] IDX_Q   = 32'hFFFF_FFFE;

  function automatic int segs(input int w, input int si_w);
    return (w + si_w - 1) / si_w;
  endfunction

  function automatic int n_w(input int n, input int i);
    return $clog2(n + i + 2);
  endfunction

  function automatic int mask_w(input int k);
    return 1 << k;
  endfunction

  function automatic int idx_segs(input int n, input int i, input int si_w);
    return segs(n_w(n, i), si_w);
  endfunction

  function automatic int mask_segs(input int k, input int si_w);
    return segs(mask_w(k), si_w);
  endfunction

  function automatic int ll(input int n, input int k, input int i, input int si_w);
    return k * idx_segs(n, i, si_w) + mask_segs(k, si_w);
  endfunction

endpackage

// File: rtl/s4ga_seg_ctl.sv
// LUT/field/segment counters for the configuration stream. Only valid beats
// advance state; the strobes describe the beat being consumed this cycle.
module s4ga_seg_ctl #(
  parameter int N         = 7,
  parameter int K         = 3,
  parameter int IDX_SEGS  = 1,
  parameter int MASK_SEGS = 2,
  parameter int N_CW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            si_valid,
  output logic [N_CW-1:0] n,
  output logic            field_done,
  output logic            lut_done,
  output logic            frame_done
);

  localparam int K_CW    = $clog2(K + 1);
  localparam int SEG_MAX = (IDX_SEGS > MASK_SEGS) ? IDX_SEGS : MASK_SEGS;
  localparam int SC_W    = (SEG_MAX > 1) ? $clog2(SEG_MAX) : 1;

  logic [K_CW-1:0] k;
  logic [SC_W-1:0] seg;
  logic            in_mask;
  logic            last_seg;

  assign in_mask    = (k == K_CW'(K));
  assign last_seg   = in_mask ? (seg == SC_W'(MASK_SEGS - 1))
                              : (seg == SC_W'(IDX_SEGS - 1));
  assign field_done = si_valid && !in_mask && last_seg;
  assign lut_done   = si_valid && in_mask && last_seg;
  assign frame_done = lut_done && (n == N_CW'(N - 1));

  // NOTE: state registers use non-blocking assignments so every counter sees
  // the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      n   <= '0;
      k   <= '0;
      seg <= '0;
    end else if (si_valid) begin
      if (last_seg) begin
        seg <= '0;
        if (in_mask) begin
          k <= '0;
          n <= frame_done ? '0 : n + 1'b1;
        end else begin
          k <= k + 1'b1;
        end
      end else begin
        seg <= seg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/s4ga_sync.sv
// Serially configured LUT fabric: decodes index fields into a K-bit input
// vector and evaluates one LUT per received record, in place or double-buffered.
module s4ga_sync
  import s4ga_pkg::*;
#(
  parameter int N    = 7,
  parameter int K    = 3,
  parameter int I    = 2,
  parameter int O    = 2,
  parameter int SI_W = 4,
  parameter int MODE = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SI_W-1:0] si,
  input  logic            si_valid,
  input  logic [I-1:0]    inputs,
  output logic [O-1:0]    outputs,
  output logic            frame
);

  localparam int    N_W       = n_w(N, I);
  localparam int    MASK_W    = mask_w(K);
  localparam int    IDX_SEGS  = idx_segs(N, I, SI_W);
  localparam int    MASK_SEGS = mask_segs(K, SI_W);
  localparam int    MAX_W     = (N_W > MASK_W) ? N_W : MASK_W;
  localparam int    SR_W      = (MAX_W > SI_W) ? (MAX_W - SI_W) : 1;
  localparam int    N_CW      = (N > 1) ? $clog2(N) : 1;
  localparam mode_e MODE_E    = mode_e'(MODE[0]);

  logic [N_CW-1:0]      n;
  logic                 field_done, lut_done, frame_done;
  logic [SR_W-1:0]      sr;
  logic [SR_W+SI_W-1:0] sr_cat;
  logic [N_W-1:0]       idx;
  logic [MASK_W-1:0]    mask;
  logic [K-1:0]         ins;
  logic [N-1:0]         cur, nxt, upd;
  logic                 q, dec, lut;

  s4ga_seg_ctl #(
    .N        (N),
    .K        (K),
    .IDX_SEGS (IDX_SEGS),
    .MASK_SEGS(MASK_SEGS),
    .N_CW     (N_CW)
  ) u_seg_ctl (
    .clk       (clk),
    .rst       (rst),
    .si_valid  (si_valid),
    .n         (n),
    .field_done(field_done),
    .lut_done  (lut_done),
    .frame_done(frame_done)
  );

  // Fields end on the current beat, so each is the low bits of {sr, si}.
  assign sr_cat = {sr, si};
  assign idx    = sr_cat[N_W-1:0];
  assign mask   = sr_cat[MASK_W-1:0];
  assign lut    = mask[ins];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    dec = 1'b0;
    for (int j = 0; j < N; j++)
      if (idx == N_W'(j)) dec = cur[j];
    for (int j = 0; j < I; j++)
      if (idx == N_W'(N + j)) dec = inputs[j];
    if (idx == IDX_Q[N_W-1:0])   dec = q;
    if (idx == IDX_ONE[N_W-1:0]) dec = 1'b1;
  end

  // Frame image with the LUT being evaluated merged in.
  always_comb begin
    upd = (MODE_E == SYNC) ? nxt : cur;
    for (int j = 0; j < N; j++)
      if (n == N_CW'(j)) upd[j] = lut;
  end

  // NOTE: the LUT value arrays are reset so a frame after reset starts from zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur     <= '0;
      nxt     <= '0;
      ins     <= '0;
      q       <= 1'b0;
      sr      <= '0;
      outputs <= '0;
      frame   <= 1'b0;
    end else begin
      frame <= frame_done;
      if (si_valid)   sr  <= sr_cat[SR_W-1:0];
      if (field_done) ins <= {ins[K-2:0], dec};
      if (lut_done) begin
        q <= mask[ins[K-2:0]];
        if (MODE_E == SYNC) nxt <= upd;
        else                cur <= upd;
      end
      if (frame_done) begin
        outputs <= upd[N-1 -: O];
        if (MODE_E == SYNC) cur <= upd;
      end
    end
  end

endmodule

// File: tb/tb_s4ga_sync.sv
// Table-driven bench for s4ga_sync: sequential and double-buffered instances
// share one stream; a scoreboard holds the expected outputs and pulse cycle per frame.
module tb_s4ga_sync;

  localparam int N = 7, K = 3, I = 2, O = 2, SI_W = 4;

  typedef struct packed {
    logic [3:0] i0, i1, i2;
    logic [7:0] mask;
  } lut_t;
  typedef lut_t [N-1:0] prog_t;

  typedef struct {
    string          name;
    prog_t          prog;
    logic [I-1:0]   in;
    logic [O-1:0]   exp0;
    logic [O-1:0]   exp1;
  } vec_t;

  typedef struct {
    string        name;
    logic [O-1:0] exp0;
    logic [O-1:0] exp1;
    int           due;
  } sb_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            si_valid = 1'b0;
  logic [SI_W-1:0] si = '0;
  logic [I-1:0]    inputs = '0;
  logic [O-1:0]    out0, out1;
  logic            frame0, frame1;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  sb_t  sb_q[$];
  vec_t vecs[8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  s4ga_sync #(.N(N), .K(K), .I(I), .O(O), .SI_W(SI_W), .MODE(0)) dut (
    .clk(clk), .rst(rst), .si(si), .si_valid(si_valid),
    .inputs(inputs), .outputs(out0), .frame(frame0)
  );

  s4ga_sync #(.N(N), .K(K), .I(I), .O(O), .SI_W(SI_W), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .si(si), .si_valid(si_valid),
    .inputs(inputs), .outputs(out1), .frame(frame1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic lut_t mk(input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] c, input logic [7:0] m);
    lut_t l;
    l = {a, b, c, m};
    return l;
  endfunction

  function automatic prog_t blank();
    prog_t p;
    for (int j = 0; j < N; j++) p[j] = mk(4'd15, 4'd15, 4'd15, 8'h00);
    return p;
  endfunction

  // Drives one frame; the expected result is queued with the last beat.
  task automatic send_frame(input vec_t v, input bit stall);
    logic [3:0] b[5];
    inputs = v.in;
    for (int j = 0; j < N; j++) begin
      b[0] = v.prog[j].i0;
      b[1] = v.prog[j].i1;
      b[2] = v.prog[j].i2;
      b[3] = v.prog[j].mask[7:4];
      b[4] = v.prog[j].mask[3:0];
      for (int s = 0; s < 5; s++) begin
        si       = b[s];
        si_valid = 1'b1;
        if (j == N - 1 && s == 4) sb_q.push_back('{v.name, v.exp0, v.exp1, cyc + 1});
        @(negedge clk);
        if (stall) begin
          si_valid = 1'b0;
          si       = 4'($urandom);
          @(negedge clk);
        end
      end
    end
    si_valid = 1'b0;
  endtask

  // Scoreboard consumer: each frame pulse pops exactly one expectation.
  always @(negedge clk) begin
    sb_t e;
    if (frame0 === 1'b1 || frame1 === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_frame: frame=%b/%b with nothing expected at cycle %0d",
                 frame0, frame1, cyc);
      end else begin
        e = sb_q.pop_front();
        check({e.name, "_out_seq"},  32'(out0),   32'(e.exp0));
        check({e.name, "_out_sync"}, 32'(out1),   32'(e.exp1));
        check({e.name, "_frame0"},   32'(frame0), 32'd1);
        check({e.name, "_frame1"},   32'(frame1), 32'd1);
        check({e.name, "_cycle"},    32'(cyc),    32'(e.due));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    prog_t p;

    p = blank();
    for (int j = 0; j < N; j++) p[j] = mk(4'd15, 4'd15, 4'd15, 8'h80);
    vecs[0] = '{"const", p, 2'b00, 2'b11, 2'b11};

    p = blank();
    p[6] = mk(4'd8, 4'd15, 4'd15, 8'hF0);
    vecs[1] = '{"in_hi", p, 2'b10, 2'b10, 2'b10};
    vecs[2] = '{"in_lo", p, 2'b00, 2'b00, 2'b00};

    p = blank();
    p[5] = mk(4'd15, 4'd15, 4'd15, 8'h80);
    p[6] = mk(4'd5, 4'd15, 4'd15, 8'hF0);
    vecs[3] = '{"mode_f1", p, 2'b00, 2'b11, 2'b01};
    vecs[4] = '{"mode_f2", p, 2'b00, 2'b11, 2'b11};

    p = blank();
    p[4] = mk(4'd15, 4'd15, 4'd15, 8'hAF);
    p[5] = mk(4'd14, 4'd15, 4'd15, 8'hF0);
    vecs[5] = '{"half_af", p, 2'b00, 2'b01, 2'b01};
    p[4] = mk(4'd15, 4'd15, 4'd15, 8'h0F);
    vecs[6] = '{"half_0f", p, 2'b00, 2'b01, 2'b01};
    p[4] = mk(4'd15, 4'd15, 4'd15, 8'hA0);
    vecs[7] = '{"half_a0", p, 2'b00, 2'b00, 2'b00};

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_out_seq",  32'(out0),   32'd0);
    check("reset_out_sync", 32'(out1),   32'd0);
    check("reset_frame",    32'(frame0), 32'd0);
    rst = 1'b0;

    for (int v = 0; v < 8; v++) send_frame(vecs[v], 1'b0);

    // Constants again with si_valid toggling; garbage on si during stalls.
    vecs[0].name = "stall_const";
    send_frame(vecs[0], 1'b1);

    // Abandon a frame after 12 beats; reset wins over a valid beat on the same edge.
    for (int s = 0; s < 12; s++) begin
      si       = (s % 5 == 3) ? 4'h8 : (s % 5 == 4) ? 4'h0 : 4'hF;
      si_valid = 1'b1;
      @(negedge clk);
    end
    rst      = 1'b1;
    si       = 4'hF;
    si_valid = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    si_valid = 1'b0;
    check("midreset_out_seq",  32'(out0),   32'd0);
    check("midreset_out_sync", 32'(out1),   32'd0);
    check("midreset_frame",    32'(frame0), 32'd0);

    vecs[1].name = "after_reset";
    send_frame(vecs[1], 1'b0);

    repeat (4) @(negedge clk);
    check("queue_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/s4ga_sync.md
# s4ga_sync

Second-generation serially configured LUT fabric. It consumes a stream of per-LUT configuration segments and evaluates one K-input LUT per received LUT frame. It adds three things the first generation lacks:

- a valid-qualified input stream that can stall,
- directly addressable FPGA inputs, so no LUTs are sacrificed to inputs,
- a MODE parameter that selects either sequential (in-place) or synchronous (double-buffered) evaluation semantics.

It sits between the configuration/stimulus source and the chip-level output pins.

## Interface
Parameters:
- N, 7: number of LUTs.
- K, 3: inputs per LUT, K ≥ 2.
- I, 2: number of FPGA inputs.
- O, 2: number of FPGA outputs, O ≤ N.
- SI_W, 4: configuration segment width.
- MODE, 0: 0 = sequential, 1 = synchronous double-buffered.

Ports:
- clk  in  1  clock; one clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- si  in  SI_W  configuration segment.
- si_valid  in  1  `si` is consumed on an edge only when si_valid=1.
- inputs  in  I  FPGA inputs, sampled when an index field addresses them.
- outputs  out  O  registered FPGA outputs.
- frame  out  1  one-cycle pulse when a full N-LUT frame completes.

## Operation
Derived widths and counts:
- N_W = clog2(N+I+2).
- MASK_W = 2^K.
- IDX_SEGS = ceil(N_W/SI_W).
- MASK_SEGS = ceil(MASK_W/SI_W).
- LL = K·IDX_SEGS + MASK_SEGS valid beats per LUT.

LUT record format:
- K index fields, then the mask.
- Each field is sent MSB segment first and padded up to a whole number of segments.
- The shift register keeps the low MAX_W bits of {sr, si}.

Index decode (idx):
- all-ones: constant 1.
- all-ones with LSB 0: the half-LUT register q.
- idx < N: LUT output cur[idx].
- N ≤ idx < N+I: inputs[idx−N].
- any other value: 0.

Input vector `ins`:
- Shifts left as fields complete: ins <= {ins, in}.
- After the last field, ins[0] holds field K−1 and ins[K−1] holds field 0.

On the last mask beat for LUT n:
- lut = mask[ins].
- q <= mask[ins[K−2:0]], i.e. the low half of the mask.
- Write target:
  - MODE 0: cur[n] <= lut, so later LUTs in the same frame see the new value.
  - MODE 1: nxt[n] <= lut. Every read in the frame sees the previous frame's cur.
- n increments. When n = N−1 instead:
  - n wraps to 0,
  - MODE 1 copies cur <= nxt, with the lut bit for N−1 merged in,
  - outputs[o] <= lut value of LUT N−O+o (the freshly evaluated value for o = O−1),
  - frame pulses for 1 cycle.

State machine over counters n ∈ [0,N), k ∈ [0,K], seg:
- IDX (k < K): advance seg on each valid beat. At seg = IDX_SEGS−1: shift in, k++, seg = 0.
- MASK (k = K): advance seg. At seg = MASK_SEGS−1: evaluate, k = 0, seg = 0.
- si_valid = 0 freezes all state; frame stays 0.

Reset (single cycle is sufficient) drives:
- cur, nxt, ins, q, n, k, seg, sr → 0,
- outputs = 0, frame = 0.

Reset mid-frame discards the partial LUT. The next valid beat is treated as LUT 0, field 0.

## Timing
- Latency from a frame's last beat to outputs/frame: 1 edge. Both are registered on the same edge.
- One frame = N·LL valid beats. Back-to-back frames have no bubble.
- inputs are sampled on the edge consuming that index field's last segment.
- rst takes priority over si_valid on the same edge.

## Structure
- Shared package s4ga_pkg holds:
  - the functions for segs(w, si_w), N_W, MASK_W, IDX_SEGS, MASK_SEGS, LL,
  - the MODE enum {SEQ, SYNC},
  - the decode constants IDX_ONE (all-ones) and IDX_Q (all-ones with LSB 0).
- One natural sub-module, s4ga_seg_ctl: the n/k/seg counter FSM with valid qualification. It emits field_done, lut_done and frame_done strobes.
- Datapath (decode, masks, cur/nxt) stays in the top module.

## Test plan
All cases use defaults: N=7, K=3, I=2, O=2, SI_W=4, giving N_W=4, LL=5, 35 beats per frame.
- Reset: stream 12 beats, then rst=1 for 1 cycle → outputs=00, frame=0; the next 35 beats form a complete frame.
- Constants: every LUT gets idx 15,15,15 and mask 0x80 (beats F,F,F,8,0) → after beat 35, frame=1 for one cycle and outputs=11.
- Inputs: LUT6 gets idx 8,15,15 (inputs[1]) with mask 0xF0; other LUTs get mask 0x00; inputs=10 → outputs=10. With inputs=00 on the next frame → outputs=00.
- Stall: same stream as the Constants case, with si_valid alternating 1/0 → frame pulses 69 cycles after the first beat; results identical.
- MODE: LUT5 = constant 1; LUT6 = idx 5,15,15 with mask 0xF0.
  - MODE 0 → outputs=11 after frame 1.
  - MODE 1 → outputs=01 after frame 1, then 11 after frame 2.
- Half-LUT: LUT4 uses mask 0x0F with idx 15,15,15, so q=1 (the low-half bit at ins[1:0]=11). LUT5 = idx 14,15,15 with mask 0xF0 → out[0]=1. Mask 0xAF gives out[0]=1; mask 0xA0 gives 0.
